// File: rtl/async_fifo_pkg.sv
// Shared types for the async FIFO and its read-side
// stream adapter.
package async_fifo_pkg;

  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_FULL  = 2'd2
  } ob_state_e;

  localparam int unsigned OB_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_stream.sv
// Registered valid/ready master fed from the FIFO pop port.
// Two-slot skid buffer keeps m_ready off the rinc path.
module fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       ocnt
);

  ob_state_e        state_q, state_d;
  logic             wsel_q, wsel_d;
  logic             rsel_q, rsel_d;
  logic [DSIZE-1:0] slot_q [OB_DEPTH];
  logic [DSIZE-1:0] slot_d [OB_DEPTH];
  logic             push;
  logic             drain;

  assign rinc    = !rempty && (state_q != OB_FULL);
  assign m_valid = (state_q != OB_EMPTY);
  assign m_data  = slot_q[rsel_q];
  assign ocnt    = state_q;

  assign push  = rinc;
  assign drain = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    slot_d  = slot_q;
    if (push) begin
      slot_d[wsel_q] = rdata;
      wsel_d         = !wsel_q;
    end
    if (drain) begin
      rsel_d = !rsel_q;
    end
    unique case (state_q)
      OB_EMPTY: begin
        if (push) state_d = OB_ONE;
      end
      OB_ONE: begin
        unique case (1'b1)
          push && !drain: state_d = OB_FULL;
          !push && drain: state_d = OB_EMPTY;
          default:        state_d = OB_ONE;
        endcase
      end
      OB_FULL: begin
        if (drain) state_d = OB_ONE;
      end
      // 2'd3 is unreachable; fall back to empty
      default: state_d = OB_EMPTY;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q   <= OB_EMPTY;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
    end
  end

  a_state_legal: assert property (
    @(posedge rclk) disable iff (!rrst_n)
    ocnt != 2'd3
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a
// behavioural FIFO model on the read side.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [1:0] ocnt;

  fifo_rd_stream #(.DSIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .ocnt    (ocnt)
  );

  always #5 rclk = ~rclk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rinc_cnt = 0;
  int valid_cnt = 0;
  int xfer_cnt = 0;
  int first_x = -1;
  int last_x = -1;
  int max_ocnt = 0;
  logic pop_now = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // FIFO model: pop on the edge where rinc was high
  always @(negedge rclk) pop_now = rinc;

  initial begin
    forever begin
      @(posedge rclk);
      #1;
      if (pop_now && fifo_q.size() > 0)
        void'(fifo_q.pop_front());
      rempty = !rrst_n || (fifo_q.size() == 0);
      rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  always @(negedge rrst_n) begin
    fifo_q.delete();
    rempty = 1'b1;
  end

  // Monitor: transfers, stall stability, protocol
  initial begin
    forever begin
      @(negedge rclk);
      cyc++;
      if (rinc) rinc_cnt++;
      if (m_valid) valid_cnt++;
      if (int'(ocnt) > max_ocnt) max_ocnt = int'(ocnt);
      if (rinc && rempty) chk("rinc_when_empty", 1, 0);
      if (rinc && ocnt == 2'd2) chk("rinc_when_full", 1, 0);
      if (prev_stall && rrst_n) begin
        chk("stall_valid", {31'd0, m_valid}, 1);
        chk("stall_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {24'd0, m_data}, 32'hFFFF);
        end else begin
          chk("data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
        xfer_cnt++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic wait_drain(input string name, input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < maxc) begin
      @(posedge rclk);
      n++;
    end
    #2;
    if (n >= maxc) chk({name, "_timeout"}, 1, 0);
  endtask

  int r0, v0, x0;

  initial begin
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_ocnt", {30'd0, ocnt}, 0);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    chk("rst_rinc", {31'd0, rinc}, 0);
    @(posedge rclk);
    #2;
    rrst_n = 1'b1;
    repeat (2) @(posedge rclk);
    #2;

    // single word
    m_ready = 1'b1;
    r0 = rinc_cnt; v0 = valid_cnt; max_ocnt = 0;
    push_word(8'hA5);
    wait_drain("single", 20);
    repeat (2) @(posedge rclk);
    #2;
    chk("single_rinc", rinc_cnt - r0, 1);
    chk("single_valid", valid_cnt - v0, 1);
    chk("single_maxocnt", max_ocnt, 1);
    chk("single_ocnt_end", {30'd0, ocnt}, 0);

    // streaming 16 words
    max_ocnt = 0; x0 = xfer_cnt; first_x = -1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    wait_drain("stream", 60);
    chk("stream_count", xfer_cnt - x0, 16);
    chk("stream_span", last_x - first_x, 15);
    chk("stream_maxocnt", max_ocnt, 1);

    // backpressure
    m_ready = 1'b0;
    r0 = rinc_cnt;
    for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
    repeat (8) @(posedge rclk);
    #2;
    chk("bp_rinc", rinc_cnt - r0, 2);
    chk("bp_ocnt", {30'd0, ocnt}, 2);
    chk("bp_data", {24'd0, m_data}, 32'h10);
    x0 = xfer_cnt;
    m_ready = 1'b1;
    repeat (4) @(negedge rclk);
    #1;
    chk("bp_nogap", xfer_cnt - x0, 4);
    wait_drain("bp", 20);

    // random ready over 256 words
    x0 = xfer_cnt;
    for (int i = 0; i < 256; i++) push_word(8'(i * 7 + 3));
    for (int n = 0; n < 3000 && exp_q.size() != 0; n++) begin
      @(posedge rclk);
      #2;
      m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    wait_drain("rand", 20);
    chk("rand_count", xfer_cnt - x0, 256);

    // reset with two words buffered
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(8'hC0 + 8'(i));
    for (int n = 0; n < 20 && ocnt != 2'd2; n++) begin
      @(posedge rclk);
      #2;
    end
    chk("mid_full", {30'd0, ocnt}, 2);
    rrst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_valid", {31'd0, m_valid}, 0);
    chk("mid_ocnt", {30'd0, ocnt}, 0);
    r0 = rinc_cnt;
    repeat (3) @(posedge rclk);
    #2;
    chk("mid_norinc", rinc_cnt - r0, 0);
    rrst_n = 1'b1;
    m_ready = 1'b1;
    x0 = xfer_cnt;
    push_word(8'h5A);
    wait_drain("post_rst", 20);
    chk("post_rst_count", xfer_cnt - x0, 1);

    repeat (2) @(posedge rclk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
